// File: rtl/s2p_pkg.sv
// Shared types and defaults for the serial-to-parallel deserializer.
package s2p_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } s2p_state_e;

  localparam int unsigned S2P_W_DEFAULT = 4;

endpackage

// File: rtl/s2p_deser.sv
// Rebuilds W-bit LSB-first words from a gapped serial stream into a valid/ready output register.
// Define S2P_PARITY_EN to expect one even-parity bit after each word and report parity_err_o.
module s2p_deser
  import s2p_pkg::*;
#(
  parameter int unsigned W = S2P_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         serial_i,
  input  logic         valid_i,
  output logic [W-1:0] parallel_o,
  output logic         pvalid_o,
  input  logic         pready_i,
  output logic         busy_o,
  output logic         overflow_o,
  output logic         parity_err_o
);

  localparam int unsigned CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LastIdx = CW'(W - 1);

  s2p_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_shift;
  logic [W-1:0]  r_parallel;
  logic          r_pvalid;
  logic          r_overflow;

  s2p_state_e    w_state_d;
  logic [CW-1:0] w_cnt_d;
  logic [W-1:0]  w_shift_d;
  logic [W-1:0]  w_word;
  logic          w_complete;
  logic          w_load;
`ifdef S2P_PARITY_EN
  logic          w_perr;
  logic          r_parity_err;
`endif

  // Collection FSM; flush wins over any bit (including a completing one) in the same cycle.
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_shift_d  = r_shift;
    w_word     = r_shift;
    w_complete = 1'b0;
`ifdef S2P_PARITY_EN
    w_perr     = 1'b0;
`endif
    if (flush_i) begin
      w_state_d = S_IDLE;
      w_cnt_d   = '0;
      w_shift_d = '0;
    end else if (valid_i) begin
      case (r_state)
        S_IDLE: begin
          w_shift_d = {{(W - 1){1'b0}}, serial_i};
          w_cnt_d   = CW'(1);
          w_state_d = S_DATA;
        end
        S_DATA: begin
          for (int i = 0; i < int'(W); i++) begin
            if (r_cnt == CW'(i)) w_shift_d[i] = serial_i;
          end
          if (r_cnt == LastIdx) begin
            w_cnt_d = '0;
`ifdef S2P_PARITY_EN
            w_state_d = S_PARITY;
`else
            w_state_d  = S_IDLE;
            w_complete = 1'b1;
            w_word     = w_shift_d;
`endif
          end else begin
            w_cnt_d = r_cnt + CW'(1);
          end
        end
`ifdef S2P_PARITY_EN
        S_PARITY: begin
          w_state_d  = S_IDLE;
          w_complete = 1'b1;
          w_word     = r_shift;
          w_perr     = ^{r_shift, serial_i};
        end
`endif
        default: begin
          w_state_d = S_IDLE;
          w_cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_shift <= w_shift_d;
    end
  end

  // A finished word loads if the register is empty or being drained this edge; otherwise dropped.
  assign w_load = w_complete & (~r_pvalid | pready_i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_parallel <= '0;
      r_pvalid   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_complete & r_pvalid & ~pready_i;
      if (w_load) begin
        r_parallel <= w_word;
        r_pvalid   <= 1'b1;
      end else if (pready_i) begin
        r_pvalid   <= 1'b0;
      end
    end
  end

`ifdef S2P_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_parity_err <= 1'b0;
    end else if (w_load) begin
      r_parity_err <= w_perr;
    end
  end

  assign parity_err_o = r_parity_err;
`else
  assign parity_err_o = 1'b0;
`endif

  assign parallel_o = r_parallel;
  assign pvalid_o   = r_pvalid;
  assign overflow_o = r_overflow;
  assign busy_o     = (r_cnt != '0) | (r_state == S_PARITY);

endmodule
